// File: rtl/relu_sequencer_if.sv
// Valid/ready word stream used on both sides of the relu sequencer.
// The producer holds the master modport and the consumer holds the slave modport.
interface relu_sequencer_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/relu_sequencer.sv
// Job-level controller for the relu datapath: admits a configured number of words into the
// fixed-latency relu and buffers its results in a credit-protected output FIFO.
module relu_sequencer #(
  parameter int NUM_WIDTH    = 16,
  parameter int LEN_WIDTH    = 16,
  parameter int RELU_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LEN_WIDTH-1:0] cfg_length,
  input  logic                 cfg_bypass,
  input  logic                 abort,
  relu_sequencer_if.slave      up,
  output logic                 relu_bypass,
  output logic [NUM_WIDTH-1:0] relu_up_data,
  input  logic [NUM_WIDTH-1:0] relu_dn_data,
  relu_sequencer_if.master     dn,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;
  localparam int CREDIT_W = CW + 1;
  localparam logic [CREDIT_W-1:0] DEPTH_C = CREDIT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [RELU_LATENCY-1:0] pipeValid;
  logic [CW-1:0]         inFlight;
  logic [CW-1:0]         fifoCount;
  logic [PW-1:0]         rdPtr;
  logic [PW-1:0]         wrPtr;
  logic [NUM_WIDTH-1:0]  mem [FIFO_DEPTH];

  logic                  upReady;
  logic                  accept;
  logic                  pipeOut;
  logic                  pop;
  logic [CREDIT_W-1:0]   credit;

  // Words already in the relu count against FIFO space, so a push can never find it full.
  always_comb begin
    credit  = {1'b0, fifoCount} + {1'b0, inFlight};
    upReady = (state == RUN) && (remaining != '0) && (credit < DEPTH_C);
    accept  = upReady && up.valid;
    pipeOut = pipeValid[RELU_LATENCY-1];
    pop     = dn.ready && (fifoCount != '0);
  end

  assign up.ready     = upReady;
  assign cfg_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign relu_up_data = accept ? up.data : '0;
  assign dn.valid     = (fifoCount != '0);
  assign dn.data      = (fifoCount != '0) ? mem[rdPtr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      pipeValid   <= '0;
      inFlight    <= '0;
      fifoCount   <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      relu_bypass <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      // Abort wins over every accept, push and pop happening in the same cycle.
      if (abort && state != IDLE) begin
        state     <= IDLE;
        remaining <= '0;
        pipeValid <= '0;
        inFlight  <= '0;
        fifoCount <= '0;
        rdPtr     <= '0;
        wrPtr     <= '0;
        aborted   <= 1'b1;
      end else begin
        pipeValid[0] <= accept;
        for (int i = 1; i < RELU_LATENCY; i++) pipeValid[i] <= pipeValid[i-1];
        inFlight <= inFlight + CW'(accept) - CW'(pipeOut);

        if (pipeOut) begin
          mem[wrPtr] <= relu_dn_data;
          wrPtr      <= wrPtr + PW'(1);
        end
        if (pop) rdPtr <= rdPtr + PW'(1);
        if (pipeOut && !pop)      fifoCount <= fifoCount + CW'(1);
        else if (pop && !pipeOut) fifoCount <= fifoCount - CW'(1);

        if (accept) remaining <= remaining - LEN_WIDTH'(1);

        case (state)
          IDLE: begin
            if (cfg_valid) begin
              relu_bypass <= cfg_bypass;
              remaining   <= cfg_length;
              if (cfg_length != '0) state <= RUN;
              else                  done  <= 1'b1;
            end
          end
          RUN: begin
            if (accept && remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
          DRAIN: begin
            if (inFlight == '0 && fifoCount == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
